// File: rtl/trena_serial_pkg.sv
// Shared constants and state encodings for the trena serial receiver.
package trena_serial_pkg;

    localparam logic [6:0] CHAR_HASH = 7'h23;
    localparam logic [6:0] CHAR_ZERO = 7'h30;
    localparam logic [6:0] CHAR_NOVE = 7'h39;

    // Frame parser states; the encoding is shown on the display as db_estado.
    typedef enum logic [3:0] {
        ESPERA_D2   = 4'd0,
        ESPERA_D1   = 4'd1,
        ESPERA_D0   = 4'd2,
        ESPERA_HASH = 4'd3,
        SINCRONIZA  = 4'd4
    } estado_parser_t;

    // Byte receiver states, one per bit slot of a 7E2 character.
    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        INICIO   = 3'd1,
        DADOS    = 3'd2,
        PARIDADE = 3'd3,
        PARADA1  = 3'd4,
        PARADA2  = 3'd5
    } estado_rx_t;

    // True when the character is an ASCII decimal digit.
    function automatic logic eh_digito(input logic [6:0] c);
        return (c >= CHAR_ZERO) && (c <= CHAR_NOVE);
    endfunction

endpackage

// File: rtl/rx_serial_7E2.sv
// 7E2 byte receiver: input synchroniser, bit timing counter and bit-slot FSM.
// Emits a one-cycle byte_ok with the character and its validity checks.
module rx_serial_7E2
    import trena_serial_pkg::*;
#(
    parameter int CLKS_POR_BIT = 434,
    parameter int MEIO_BIT     = CLKS_POR_BIT / 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       entrada_serial,
    output logic [6:0] dado,
    output logic       byte_ok,
    output logic       paridade_ok,
    output logic       parada_ok
);

    localparam int CW = $clog2(CLKS_POR_BIT);
    localparam logic [CW-1:0] FIM_BIT  = CW'(CLKS_POR_BIT - 1);
    localparam logic [CW-1:0] FIM_MEIO = CW'(MEIO_BIT - 1);

    logic          sync1_q, sync2_q;
    estado_rx_t    estado_q, estado_d;
    logic [CW-1:0] cont_q, cont_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [6:0]    dado_q, dado_d;
    logic          paridade_bit_q, paridade_bit_d;
    logic          parada1_q, parada1_d;
    logic          byte_ok_q, byte_ok_d;
    logic          paridade_ok_q, paridade_ok_d;
    logic          parada_ok_q, parada_ok_d;

    logic rx;
    logic fim_bit;

    assign rx      = sync2_q;
    assign fim_bit = (cont_q == FIM_BIT);

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= entrada_serial;
            sync2_q <= sync1_q;
        end
    end

    // Next-state logic: each slot is sampled at its centre, then the counter restarts.
    always_comb begin
        estado_d       = estado_q;
        cont_d         = cont_q + CW'(1);
        bit_idx_d      = bit_idx_q;
        dado_d         = dado_q;
        paridade_bit_d = paridade_bit_q;
        parada1_d      = parada1_q;
        byte_ok_d      = 1'b0;
        paridade_ok_d  = paridade_ok_q;
        parada_ok_d    = parada_ok_q;
        case (estado_q)
            OCIOSO: begin
                cont_d = '0;
                if (!rx) estado_d = INICIO;
            end
            INICIO: begin
                if (cont_q == FIM_MEIO) begin
                    cont_d    = '0;
                    bit_idx_d = 3'd0;
                    // A line that is high again at mid start bit was a glitch.
                    estado_d  = rx ? OCIOSO : DADOS;
                end
            end
            DADOS: begin
                if (fim_bit) begin
                    cont_d    = '0;
                    dado_d    = {rx, dado_q[6:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd6) estado_d = PARIDADE;
                end
            end
            PARIDADE: begin
                if (fim_bit) begin
                    cont_d         = '0;
                    paridade_bit_d = rx;
                    estado_d       = PARADA1;
                end
            end
            PARADA1: begin
                if (fim_bit) begin
                    cont_d    = '0;
                    parada1_d = rx;
                    estado_d  = PARADA2;
                end
            end
            PARADA2: begin
                if (fim_bit) begin
                    cont_d        = '0;
                    byte_ok_d     = 1'b1;
                    paridade_ok_d = ~(^dado_q ^ paridade_bit_q);
                    parada_ok_d   = parada1_q & rx;
                    // Back to idle at mid stop bit so the next start edge is never missed.
                    estado_d      = OCIOSO;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    // State, counter and result registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q       <= OCIOSO;
            cont_q         <= '0;
            bit_idx_q      <= 3'd0;
            dado_q         <= 7'd0;
            paridade_bit_q <= 1'b0;
            parada1_q      <= 1'b0;
            byte_ok_q      <= 1'b0;
            paridade_ok_q  <= 1'b0;
            parada_ok_q    <= 1'b0;
        end else begin
            estado_q       <= estado_d;
            cont_q         <= cont_d;
            bit_idx_q      <= bit_idx_d;
            dado_q         <= dado_d;
            paridade_bit_q <= paridade_bit_d;
            parada1_q      <= parada1_d;
            byte_ok_q      <= byte_ok_d;
            paridade_ok_q  <= paridade_ok_d;
            parada_ok_q    <= parada_ok_d;
        end
    end

    assign dado        = dado_q;
    assign byte_ok     = byte_ok_q;
    assign paridade_ok = paridade_ok_q;
    assign parada_ok   = parada_ok_q;

endmodule

// File: rtl/trena_receptor_serial.sv
// Trena serial link receiver: parses "DDD#" frames into a 12-bit BCD measurement.
module trena_receptor_serial
    import trena_serial_pkg::*;
#(
    parameter int CLKS_POR_BIT = 434,
    parameter int MEIO_BIT     = CLKS_POR_BIT / 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        entrada_serial,
    output logic [11:0] medida,
    output logic        pronto,
    output logic [6:0]  dado_recebido,
    output logic        erro_paridade,
    output logic        erro_quadro,
    output logic        erro_formato,
    output logic [3:0]  db_estado
);

    logic [6:0] rx_dado;
    logic       rx_byte_ok;
    logic       rx_paridade_ok;
    logic       rx_parada_ok;

    rx_serial_7E2 #(
        .CLKS_POR_BIT (CLKS_POR_BIT),
        .MEIO_BIT     (MEIO_BIT)
    ) u_rx (
        .clock          (clock),
        .reset          (reset),
        .entrada_serial (entrada_serial),
        .dado           (rx_dado),
        .byte_ok        (rx_byte_ok),
        .paridade_ok    (rx_paridade_ok),
        .parada_ok      (rx_parada_ok)
    );

    estado_parser_t estado_q, estado_d;
    logic [3:0]  dig2_q, dig2_d;
    logic [3:0]  dig1_q, dig1_d;
    logic [3:0]  dig0_q, dig0_d;
    logic [11:0] medida_q, medida_d;
    logic        pronto_q, pronto_d;
    logic [6:0]  dado_rec_q, dado_rec_d;
    logic        erro_par_q, erro_par_d;
    logic        erro_quadro_q, erro_quadro_d;
    logic        erro_formato_q, erro_formato_d;

    // Frame parser: digits go to shadow registers; medida is only written on '#'.
    always_comb begin
        estado_d       = estado_q;
        dig2_d         = dig2_q;
        dig1_d         = dig1_q;
        dig0_d         = dig0_q;
        medida_d       = medida_q;
        pronto_d       = 1'b0;
        dado_rec_d     = dado_rec_q;
        erro_par_d     = erro_par_q;
        erro_quadro_d  = erro_quadro_q;
        erro_formato_d = erro_formato_q;
        if (rx_byte_ok) begin
            dado_rec_d = rx_dado;
            if (!rx_paridade_ok || !rx_parada_ok) begin
                if (!rx_paridade_ok) erro_par_d = 1'b1;
                if (!rx_parada_ok)   erro_quadro_d = 1'b1;
                estado_d = SINCRONIZA;
            end else begin
                case (estado_q)
                    ESPERA_D2, ESPERA_D1, ESPERA_D0: begin
                        if (eh_digito(rx_dado)) begin
                            case (estado_q)
                                ESPERA_D2: begin dig2_d = rx_dado[3:0]; estado_d = ESPERA_D1;   end
                                ESPERA_D1: begin dig1_d = rx_dado[3:0]; estado_d = ESPERA_D0;   end
                                default:   begin dig0_d = rx_dado[3:0]; estado_d = ESPERA_HASH; end
                            endcase
                        end else begin
                            // A stray '#' already marks a frame boundary, so no resync is needed.
                            erro_formato_d = 1'b1;
                            estado_d = (rx_dado == CHAR_HASH) ? ESPERA_D2 : SINCRONIZA;
                        end
                    end
                    ESPERA_HASH: begin
                        if (rx_dado == CHAR_HASH) begin
                            medida_d       = {dig2_q, dig1_q, dig0_q};
                            pronto_d       = 1'b1;
                            erro_par_d     = 1'b0;
                            erro_quadro_d  = 1'b0;
                            erro_formato_d = 1'b0;
                            estado_d       = ESPERA_D2;
                        end else begin
                            erro_formato_d = 1'b1;
                            estado_d       = SINCRONIZA;
                        end
                    end
                    default: begin
                        if (rx_dado == CHAR_HASH) estado_d = ESPERA_D2;
                    end
                endcase
            end
        end
    end

    // Parser state and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q       <= ESPERA_D2;
            dig2_q         <= 4'd0;
            dig1_q         <= 4'd0;
            dig0_q         <= 4'd0;
            medida_q       <= 12'h000;
            pronto_q       <= 1'b0;
            dado_rec_q     <= 7'd0;
            erro_par_q     <= 1'b0;
            erro_quadro_q  <= 1'b0;
            erro_formato_q <= 1'b0;
        end else begin
            estado_q       <= estado_d;
            dig2_q         <= dig2_d;
            dig1_q         <= dig1_d;
            dig0_q         <= dig0_d;
            medida_q       <= medida_d;
            pronto_q       <= pronto_d;
            dado_rec_q     <= dado_rec_d;
            erro_par_q     <= erro_par_d;
            erro_quadro_q  <= erro_quadro_d;
            erro_formato_q <= erro_formato_d;
        end
    end

    assign medida        = medida_q;
    assign pronto        = pronto_q;
    assign dado_recebido = dado_rec_q;
    assign erro_paridade = erro_par_q;
    assign erro_quadro   = erro_quadro_q;
    assign erro_formato  = erro_formato_q;
    assign db_estado     = estado_q;

endmodule

// File: tb/tb_trena_receptor_serial.sv
// Bench for trena_receptor_serial: table of frames plus hand-written corner cases.
module tb_trena_receptor_serial;

    localparam int CPB  = 40;
    localparam int MEIO = CPB / 2;

    logic        clock;
    logic        reset;
    logic        entrada_serial;
    logic [11:0] medida;
    logic        pronto;
    logic [6:0]  dado_recebido;
    logic        erro_paridade;
    logic        erro_quadro;
    logic        erro_formato;
    logic [3:0]  db_estado;

    trena_receptor_serial #(
        .CLKS_POR_BIT (CPB),
        .MEIO_BIT     (MEIO)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .entrada_serial (entrada_serial),
        .medida         (medida),
        .pronto         (pronto),
        .dado_recebido  (dado_recebido),
        .erro_paridade  (erro_paridade),
        .erro_quadro    (erro_quadro),
        .erro_formato   (erro_formato),
        .db_estado      (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_mis = 0;
    int pronto_cnt = 0;
    logic [11:0] sb_q[$];

    // Scoreboard: every pronto pulse must match the next expected measurement.
    always @(negedge clock) begin
        if (!reset && pronto) begin
            pronto_cnt++;
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_mis++;
                $display("FAIL pronto_inesperado: got medida=0x%03h, required no pronto", medida);
            end else begin
                logic [11:0] exp_m;
                exp_m = sb_q.pop_front();
                if (medida !== exp_m) begin
                    n_mis++;
                    $display("FAIL sb_medida: got 0x%03h, required 0x%03h", medida, exp_m);
                end else begin
                    $display("pronto medida=0x%03h ok", medida);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp_v);
        end
    endtask

    task automatic bit_out(input logic b, input int ciclos);
        entrada_serial = b;
        repeat (ciclos) @(posedge clock);
    endtask

    // One 7E2 character; optionally corrupt the parity bit or pull stop bit 2 low.
    task automatic send_char(input logic [6:0] c, input bit bad_par, input bit bad_stop);
        bit_out(1'b0, CPB);
        for (int i = 0; i < 7; i++) bit_out(c[i], CPB);
        bit_out((^c) ^ bad_par, CPB);
        bit_out(1'b1, CPB);
        if (bad_stop) begin
            bit_out(1'b0, MEIO + 6);
            bit_out(1'b1, CPB - MEIO - 6);
        end else begin
            bit_out(1'b1, CPB);
        end
    endtask

    task automatic send_str(input string s, input int bad_par, input int bad_stop);
        for (int i = 0; i < s.len(); i++)
            send_char(7'(s[i]), (i == bad_par), (i == bad_stop));
        repeat (4) @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle(input int ciclos);
        entrada_serial = 1'b1;
        repeat (ciclos) @(posedge clock);
        @(negedge clock);
    endtask

    typedef struct {
        string       txt;
        int          bad_par;
        int          bad_stop;
        logic [11:0] exp_medida;
        logic [2:0]  exp_err;     // {paridade, quadro, formato}
        logic [3:0]  exp_estado;
        logic [6:0]  exp_dado;
        int          exp_prontos;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #20_000_000;
        $display("FAIL watchdog: got timeout, required bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        vecs[0]  = '{"123#",     -1, -1, 12'h123, 3'b000, 4'd0, 7'h23, 1};
        vecs[1]  = '{"1A3#045#", -1, -1, 12'h045, 3'b000, 4'd0, 7'h23, 1};
        vecs[2]  = '{"999#078#",  0, -1, 12'h078, 3'b000, 4'd0, 7'h23, 1};
        vecs[3]  = '{"5",        -1,  0, 12'h078, 3'b010, 4'd4, 7'h35, 0};
        vecs[4]  = '{"#",        -1, -1, 12'h078, 3'b010, 4'd0, 7'h23, 0};
        vecs[5]  = '{"12",       -1, -1, 12'h078, 3'b010, 4'd2, 7'h32, 0};
        vecs[6]  = '{"3#",       -1, -1, 12'h123, 3'b000, 4'd0, 7'h23, 1};
        vecs[7]  = '{"##",       -1, -1, 12'h123, 3'b001, 4'd0, 7'h23, 0};
        vecs[8]  = '{"9#",       -1, -1, 12'h123, 3'b001, 4'd0, 7'h23, 0};
        vecs[9]  = '{"999#",     -1, -1, 12'h999, 3'b000, 4'd0, 7'h23, 1};
        vecs[10] = '{"4X",       -1, -1, 12'h999, 3'b001, 4'd4, 7'h58, 0};
        vecs[11] = '{"2",         0, -1, 12'h999, 3'b101, 4'd4, 7'h32, 0};
        vecs[12] = '{"0#",       -1, -1, 12'h999, 3'b101, 4'd0, 7'h23, 0};
        vecs[13] = '{"000#",     -1, -1, 12'h000, 3'b000, 4'd0, 7'h23, 1};

        reset = 1'b1;
        entrada_serial = 1'b1;
        repeat (5) @(posedge clock);
        @(negedge clock);
        chk("rst_medida", medida, 12'h000);
        chk("rst_pronto", pronto, 0);
        chk("rst_dado", dado_recebido, 0);
        chk("rst_erros", {erro_paridade, erro_quadro, erro_formato}, 0);
        chk("rst_estado", db_estado, 0);
        reset = 1'b0;
        idle(2 * CPB);

        for (int v = 0; v < 14; v++) begin
            p0 = pronto_cnt;
            for (int k = 0; k < vecs[v].exp_prontos; k++) sb_q.push_back(vecs[v].exp_medida);
            send_str(vecs[v].txt, vecs[v].bad_par, vecs[v].bad_stop);
            $display("vec %0d '%s': medida=0x%03h err=%b estado=%0d dado=0x%02h prontos=%0d",
                     v, vecs[v].txt, medida, {erro_paridade, erro_quadro, erro_formato},
                     db_estado, dado_recebido, pronto_cnt - p0);
            chk("vec_medida", medida, vecs[v].exp_medida);
            chk("vec_erros", {erro_paridade, erro_quadro, erro_formato}, vecs[v].exp_err);
            chk("vec_estado", db_estado, vecs[v].exp_estado);
            chk("vec_dado", dado_recebido, vecs[v].exp_dado);
            chk("vec_prontos", pronto_cnt - p0, vecs[v].exp_prontos);
            idle(2 * CPB);
        end

        // Partial and malformed frames must not disturb medida.
        sb_q.push_back(12'h642);
        send_str("642#", -1, -1);
        send_str("1A", -1, -1);
        $display("seq 1A: medida=0x%03h formato=%b estado=%0d", medida, erro_formato, db_estado);
        chk("seq_1A_formato", erro_formato, 1);
        chk("seq_1A_medida", medida, 12'h642);
        chk("seq_1A_estado", db_estado, 4);
        p0 = pronto_cnt;
        send_str("3#", -1, -1);
        $display("seq 3#: medida=0x%03h estado=%0d", medida, db_estado);
        chk("seq_3h_medida", medida, 12'h642);
        chk("seq_3h_estado", db_estado, 0);
        chk("seq_3h_prontos", pronto_cnt - p0, 0);
        sb_q.push_back(12'h045);
        send_str("045#", -1, -1);
        $display("seq 045#: medida=0x%03h formato=%b", medida, erro_formato);
        chk("seq_045_medida", medida, 12'h045);
        chk("seq_045_formato", erro_formato, 0);

        // Short low glitch on an idle line is rejected at mid start bit.
        p0 = pronto_cnt;
        entrada_serial = 1'b0;
        repeat (10) @(posedge clock);
        idle(3 * CPB);
        $display("seq glitch: dado=0x%02h err=%b estado=%0d", dado_recebido,
                 {erro_paridade, erro_quadro, erro_formato}, db_estado);
        chk("glitch_dado", dado_recebido, 7'h23);
        chk("glitch_erros", {erro_paridade, erro_quadro, erro_formato}, 0);
        chk("glitch_estado", db_estado, 0);
        chk("glitch_prontos", pronto_cnt - p0, 0);

        // Reset in the middle of the second digit, then a clean frame.
        send_char(7'h34, 1'b0, 1'b0);
        bit_out(1'b0, CPB);
        bit_out(1'b1, CPB);
        bit_out(1'b0, CPB);
        bit_out(1'b1, CPB / 2);
        reset = 1'b1;
        entrada_serial = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        idle(2 * CPB);
        $display("seq reset: medida=0x%03h estado=%0d dado=0x%02h", medida, db_estado, dado_recebido);
        chk("rst2_medida", medida, 12'h000);
        chk("rst2_estado", db_estado, 0);
        chk("rst2_dado", dado_recebido, 0);
        p0 = pronto_cnt;
        sb_q.push_back(12'h321);
        send_str("321#", -1, -1);
        $display("seq 321#: medida=0x%03h prontos=%0d", medida, pronto_cnt - p0);
        chk("rst2_321_medida", medida, 12'h321);
        chk("rst2_321_prontos", pronto_cnt - p0, 1);

        idle(CPB);
        chk("sb_pendentes", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
